mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Round-robin arbiter and sequencer sharing the single-port parameter/tensor memory (ADDR_WIDTH-bit address, DATA_WIDTH*BANDWIDTH-bit word, 1-cycle registered read) between NUM_REQ requesters. Examples are operand fetch, weight fetch and result writeback. It accepts at most one command per cycle, drives the memory command registered, and routes read data back to the issuing requester with a tag. It sits between the layer engines and the memory wrapper.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; range 2..8.
- AW, `ADDR_WIDTH: address width.
- DW, `DATA_WIDTH*`BANDWIDTH: data word width.

Ports:
- clock  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ×AW  per-requester address.
- req_wdata  in  NUM_REQ×DW  per-requester write data.
- req_ready  out  NUM_REQ  one-hot grant; at most one bit high; combinational.
- rsp_valid  out  NUM_REQ  one-hot read-response strobe.
- rsp_rdata  out  DW  read data; 0 when no rsp_valid bit is set.
- mem_read, mem_write  out  1  registered memory command strobes; never both high.
- mem_address  out  AW  registered address.
- mem_writedata  out  DW  registered write data.
- mem_readdata  in  DW  memory read data, valid the cycle after mem_read is sampled.

## Operation
- Grant: among req_valid bits, pick the first set bit at or after ptr, wrapping at NUM_REQ-1→0.
- req_ready[winner]=1 in the same cycle. A transfer occurs when req_valid&req_ready are both high at a posedge.
- On a transfer: ptr ← winner+1 (mod NUM_REQ); the winner's command is registered into mem_*.
- For a read, the winner's index is registered as tag with an in-flight bit.
- No transfer: ptr holds; mem_read=mem_write=0 next cycle; mem_address/mem_writedata hold.
- Response: the cycle after mem_read is sampled by memory:
  - rsp_valid[tag]=1 and rsp_rdata=mem_readdata (combinational pass-through).
  - Responses have no backpressure; requesters must take them.
- Writes produce no response.
- Ordering: commands are issued in grant order, so a read granted after a write to the same address returns the new data.
- Requesters must hold req_* stable while valid and not ready.
- Reset: ptr=0, all mem_* =0, in-flight bit cleared, rsp_valid=0, rsp_rdata=0. Reset during an in-flight read drops it; no response after reset release.

## Timing
- Throughput: 1 command/cycle. Back-to-back grants to different requesters are allowed.
- A sole active requester is granted every cycle.
- Read latency: transfer at edge E0 → mem_read high during cycle E0..E1 → rsp_valid high during cycle E1..E2 (2 cycles).
- Write: mem_write high during cycle E0..E1; memory is updated at E1.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.

## Configuration
- MEM_ARB_STATS_EN defined: adds stat_grants (out, NUM_REQ×32, per-requester transfer count) and stat_conflicts (out, 32, count of cycles with ≥2 req_valid bits high).
  - All counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Package mem_arb_pkg holds:
  - NUM_REQ default.
  - typedef mem_cmd_t {write, addr[AW], wdata[DW]}.
  - Tag type sized $clog2(NUM_REQ).
- Sub-module rr_arbiter: purely combinational (req vector, ptr) → one-hot grant plus encoded index. The ptr register and the command/response pipeline live in mem_arbiter.

## Test plan
- Reset then idle: all outputs 0; mem_read=mem_write=0 for 10 cycles.
- Requester 2 alone writes addr 5 = 32'h40A00000, then reads addr 5 → rsp_valid=4'b0100 two cycles after read grant, rsp_rdata=32'h40A00000.
- All 4 requesters valid, reading addresses 10..13, for 8 cycles → grants 0,1,2,3,0,1,2,3. Responses follow in the same order, each 2 cycles after its grant.
- ptr=3, requesters 0 and 3 valid → 3 granted first, then 0 (wrap).
- Read granted, reset asserted the next cycle → no rsp_valid after reset release; ptr=0.
- With MEM_ARB_STATS_EN: 6 cycles of requesters 0 and 1 both valid → stat_grants[0]=3, stat_grants[1]=3, stat_conflicts=6.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory arbiter.
// Default word widths: 16-bit address, 32-bit data.
package mem_arb_pkg;

  localparam int NUM_REQ_DEF = 4;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 32;

  localparam int TAG_W = $clog2(NUM_REQ_DEF);
  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic              write;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } mem_cmd_t;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// Combinational round-robin pick: first request at or after ptr, wrapping at NUM_REQ-1.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      index,
  output logic               found
);

  int j;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        index    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sharing of a single-port memory with tagged read-data return.
// Optional MEM_ARB_STATS_EN adds saturating grant and conflict counters.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [AW-1:0]         mem_address,
  output logic [DW-1:0]         mem_writedata,
`ifdef MEM_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0] stat_grants,
  output logic [31:0]           stat_conflicts,
`endif
  input  logic [DW-1:0]         mem_readdata
);

  localparam int IW = $clog2(NUM_REQ);

  // Handshake: a command transfers on a posedge where req_valid[i] and req_ready[i]
  // are both high; requesters hold req_* stable until then. Responses cannot stall.
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      win_idx;
  logic               win_found;
  logic [NUM_REQ-1:0] grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .index (win_idx),
    .found (win_found)
  );

  assign req_ready = grant;

  mem_cmd_t      win_cmd;
  mem_cmd_t      cmd_q;
  logic          cmd_vld_q;
  logic          infl_q;
  logic [IW-1:0] infl_tag_q;
  logic          rsp_q;
  logic [IW-1:0] rsp_tag_q;

  always_comb begin
    win_cmd.write = req_write[win_idx];
    win_cmd.addr  = req_addr[int'(win_idx)*AW +: AW];
    win_cmd.wdata = req_wdata[int'(win_idx)*DW +: DW];
  end

  // infl_* tracks a read while the memory samples it; rsp_* is the cycle its data returns.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      cmd_vld_q  <= 1'b0;
      cmd_q      <= '0;
      infl_q     <= 1'b0;
      infl_tag_q <= '0;
      rsp_q      <= 1'b0;
      rsp_tag_q  <= '0;
    end else begin
      cmd_vld_q <= win_found;
      infl_q    <= win_found & ~win_cmd.write;
      rsp_q     <= infl_q;
      rsp_tag_q <= infl_tag_q;
      if (win_found) begin
        ptr_q      <= (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
        cmd_q      <= win_cmd;
        infl_tag_q <= win_idx;
      end
    end
  end

  assign mem_read      = cmd_vld_q & ~cmd_q.write;
  assign mem_write     = cmd_vld_q &  cmd_q.write;
  assign mem_address   = cmd_q.addr;
  assign mem_writedata = cmd_q.wdata;

  always_comb begin
    rsp_valid = '0;
    if (rsp_q) rsp_valid[rsp_tag_q] = 1'b1;
    rsp_rdata = rsp_q ? mem_readdata : '0;
  end

`ifdef MEM_ARB_STATS_EN
  logic [31:0] grant_cnt_q [NUM_REQ];
  logic [31:0] conflict_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      conflict_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (grant[i]) grant_cnt_q[i] <= sat_inc(grant_cnt_q[i]);
      if ($countones(req_valid) > 1) conflict_q <= sat_inc(conflict_q);
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants[i*32 +: 32] = grant_cnt_q[i];
  end
  assign stat_conflicts = conflict_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level model:
// the model tracks the rotation pointer, a reference memory updated in grant order,
// and an expected-response queue stamped with the cycle each response is due.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int N  = NUM_REQ_DEF;
  localparam int AW = AW_DEF;
  localparam int DW = DW_DEF;
  typedef logic [63:0] cval_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_read;
  logic            mem_write;
  logic [AW-1:0]   mem_address;
  logic [DW-1:0]   mem_writedata;
  logic [DW-1:0]   mem_readdata;
`ifdef MEM_ARB_STATS_EN
  logic [N*32-1:0] stat_grants;
  logic [31:0]     stat_conflicts;
`endif

  mem_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
`ifdef MEM_ARB_STATS_EN
    .stat_grants   (stat_grants),
    .stat_conflicts(stat_conflicts),
`endif
    .mem_readdata  (mem_readdata)
  );

  // Memory wrapper stand-in: one-cycle registered read.
  logic [DW-1:0] tb_mem [256];
  logic [DW-1:0] mem_rd = '0;
  always @(posedge clock) begin
    if (mem_write) tb_mem[mem_address[7:0]] <= mem_writedata;
    if (mem_read)  mem_rd <= tb_mem[mem_address[7:0]];
  end
  assign mem_readdata = mem_rd;

  // Reference model state.
  int            ptr_m;
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_q[$];
  int            exp_tag_q[$];
  int            exp_due_q[$];
  bit            em_read, em_write;
  logic [AW-1:0] em_addr;
  logic [DW-1:0] em_wdata;
  int            cyc;
  bit            g_found;
  int            g_idx;
  logic [31:0]   sg [N];
  logic [31:0]   sc;
  logic [N-1:0]  last_rsp_valid;
  logic [DW-1:0] last_rsp_rdata;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input cval_t got, input cval_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    ptr_m = 0;
    exp_q.delete();
    exp_tag_q.delete();
    exp_due_q.delete();
    em_read = 0; em_write = 0; em_addr = '0; em_wdata = '0;
    g_found = 0; g_idx = 0;
    for (int i = 0; i < N; i++) sg[i] = '0;
    sc = '0;
  endtask

  task automatic set_cmd(input int i, input bit v, input bit w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_write[i] = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Compares every DUT output with the model for the current cycle.
  task automatic check_cycle();
    logic [N-1:0]  e_ready;
    logic [N-1:0]  e_rv;
    logic [DW-1:0] e_rd;
    g_found = 0; g_idx = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (ptr_m + k) % N;
      if (!g_found && req_valid[j]) begin g_found = 1; g_idx = j; end
    end
    e_ready = '0;
    if (g_found) e_ready[g_idx] = 1'b1;
    check("req_ready", cval_t'(req_ready), cval_t'(e_ready));
    check("mem_read", cval_t'(mem_read), cval_t'(em_read));
    check("mem_write", cval_t'(mem_write), cval_t'(em_write));
    check("mem_address", cval_t'(mem_address), cval_t'(em_addr));
    check("mem_writedata", cval_t'(mem_writedata), cval_t'(em_wdata));
    e_rv = '0; e_rd = '0;
    if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      e_rv[exp_tag_q[0]] = 1'b1;
      e_rd = exp_q[0];
      void'(exp_due_q.pop_front());
      void'(exp_tag_q.pop_front());
      void'(exp_q.pop_front());
    end
    check("rsp_valid", cval_t'(rsp_valid), cval_t'(e_rv));
    check("rsp_rdata", cval_t'(rsp_rdata), cval_t'(e_rd));
`ifdef MEM_ARB_STATS_EN
    for (int i = 0; i < N; i++) check("stat_grants", cval_t'(stat_grants[i*32 +: 32]), cval_t'(sg[i]));
    check("stat_conflicts", cval_t'(stat_conflicts), cval_t'(sc));
`endif
    last_rsp_valid = rsp_valid;
    last_rsp_rdata = rsp_rdata;
  endtask

  // Applies the transfer (if any) decided at the edge that just happened.
  task automatic update_model();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    em_read = 0; em_write = 0;
    if (g_found) begin
      a = req_addr[g_idx*AW +: AW];
      d = req_wdata[g_idx*DW +: DW];
      ptr_m = (g_idx + 1) % N;
      em_addr = a; em_wdata = d;
      if (sg[g_idx] != 32'hFFFF_FFFF) sg[g_idx] = sg[g_idx] + 1;
      if (req_write[g_idx]) begin
        em_write = 1;
        ref_mem[a[7:0]] = d;
      end else begin
        em_read = 1;
        exp_q.push_back(ref_mem[a[7:0]]);
        exp_tag_q.push_back(g_idx);
        exp_due_q.push_back(cyc + 2);
      end
    end
    if ($countones(req_valid) > 1 && sc != 32'hFFFF_FFFF) sc = sc + 1;
    cyc++;
  endtask

  task automatic step();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    update_model();
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    model_clear();
    #1;
    check_cycle();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    g_found = 0;
    update_model();
    #1;
  endtask

  initial begin
    logic [N-1:0] seq_exp;
    cyc = 0;
    for (int i = 0; i < 256; i++) begin tb_mem[i] = '0; ref_mem[i] = '0; end
    model_clear();
    last_rsp_valid = '0; last_rsp_rdata = '0;

    // Reset, then idle.
    #2;
    check_cycle();
    do_reset();
    repeat (10) step();

    // Requester 2 alone: write then read back address 5.
    set_cmd(2, 1, 1, AW'(5), DW'(32'h40A0_0000));
    step();
    set_cmd(2, 1, 0, AW'(5), '0);
    step();
    set_cmd(2, 0, 0, '0, '0);
    step();
    step();
    check("t2_rsp_valid", cval_t'(last_rsp_valid), cval_t'(4'b0100));
    check("t2_rsp_rdata", cval_t'(last_rsp_rdata), cval_t'(32'h40A0_0000));
    repeat (2) step();

    // All four reading 10..13: grants rotate 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < N; i++) set_cmd(i, 1, 0, AW'(10 + i), '0);
    for (int k = 0; k < 8; k++) begin
      seq_exp = '0;
      seq_exp[k % N] = 1'b1;
      #3;
      check("t3_grant_seq", cval_t'(req_ready), cval_t'(seq_exp));
      step();
    end
    clear_inputs();
    repeat (3) step();

    // Pointer at 3 with requesters 0 and 3 valid: 3 first, then wrap to 0.
    do_reset();
    set_cmd(2, 1, 0, AW'(1), '0);
    step();
    set_cmd(2, 0, 0, '0, '0);
    set_cmd(0, 1, 0, AW'(2), '0);
    set_cmd(3, 1, 0, AW'(3), '0);
    #3;
    check("t4_wrap_first", cval_t'(req_ready), cval_t'(4'b1000));
    step();
    set_cmd(3, 0, 0, '0, '0);
    #3;
    check("t4_wrap_second", cval_t'(req_ready), cval_t'(4'b0001));
    step();
    clear_inputs();
    repeat (3) step();

    // Reset one cycle after a read grant: the read is dropped.
    set_cmd(1, 1, 0, AW'(10), '0);
    step();
    do_reset();
    repeat (4) step();
    check("t5_no_rsp", cval_t'(last_rsp_valid), cval_t'(0));
    set_cmd(0, 1, 0, AW'(4), '0);
    set_cmd(3, 1, 0, AW'(4), '0);
    #3;
    check("t5_ptr_zero", cval_t'(req_ready), cval_t'(4'b0001));
    clear_inputs();
    repeat (2) step();

`ifdef MEM_ARB_STATS_EN
    // Two contenders for six cycles.
    do_reset();
    set_cmd(0, 1, 0, AW'(7), '0);
    set_cmd(1, 1, 0, AW'(8), '0);
    repeat (6) step();
    check("t6_stat_g0", cval_t'(stat_grants[31:0]), cval_t'(3));
    check("t6_stat_g1", cval_t'(stat_grants[63:32]), cval_t'(3));
    check("t6_stat_conf", cval_t'(stat_conflicts), cval_t'(6));
    clear_inputs();
    repeat (3) step();
`endif

    // Random traffic over a small address window to provoke read-after-write.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || (g_found && g_idx == i)) begin
          set_cmd(i, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  AW'($urandom_range(0, 15)), DW'($urandom));
        end
      end
      step();
    end
    clear_inputs();
    repeat (4) step();
    check("final_queue_empty", cval_t'(exp_q.size()), cval_t'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
